// File: rtl/pwm_pkg.sv
// Shared definitions for the RC PWM decoder: channel FSM states, synchronizer
// depth and the parameter legality check used at elaboration.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEASURE   = 2'd2,
    OVERRUN   = 2'd3
  } pwm_state_e;

  // Flops between the raw pin and the first usable sample.
  localparam int SYNC_DEPTH = 2;

  // Edges after reset before sync stages and the edge register all hold real samples.
  localparam int PRIME_CYCLES = SYNC_DEPTH + 1;

  // Thresholds must be ordered and the saturation value must fit the counter.
  function automatic bit params_legal(input int low, input int high, input int max, input int cnt_w);
    return (low < high) && (high < max) && (cnt_w > 0) && (cnt_w < 31) && (max < (1 << cnt_w));
  endfunction

endpackage

// File: rtl/rc_pwm_decoder_if.sv
// Bundle between the pulse source side and the per-channel decoders.
// Handshake: there is no ready/backpressure. valid[k] is a one-cycle strobe;
// width[k*CNT_W +: CNT_W] and sw[k] are updated in that same cycle and stay
// stable until the next strobe. error[k] is a one-cycle overrun strobe.
// state carries each channel FSM state (2 bits per channel) for observation.
interface rc_pwm_decoder_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 12
);
  logic                    enable;
  logic [NUM_CH-1:0]       pwm;
  wire  [NUM_CH*CNT_W-1:0] width;
  wire  [NUM_CH-1:0]       valid;
  wire  [NUM_CH-1:0]       sw;
  wire  [NUM_CH-1:0]       error;
  wire  [NUM_CH-1:0]       signal_lost;
  wire  [2*NUM_CH-1:0]     state;

  modport master (
    output enable, pwm,
    input  width, valid, sw, error, signal_lost, state
  );

  modport slave (
    input  enable, pwm,
    output width, valid, sw, error, signal_lost, state
  );
endinterface

// File: rtl/pwm_channel.sv
// One RC PWM channel: 2-flop synchronizer, edge register, measurement FSM,
// saturating counter, hysteresis switch and (with FAILSAFE_EN) a signal-loss timer.
// Build option: FAILSAFE_EN adds the per-channel timeout counter.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int IDX                = 0,
  parameter int CNT_W              = 12,
  parameter int MAX_COUNTER_VALUE  = 2000,
  parameter int HIGH_COUNTER_VALUE = 1800,
  parameter int LOW_COUNTER_VALUE  = 1200,
  parameter int TIMEOUT_VALUE      = 25000
) (
  input logic        clk,
  input logic        rst_n,
  rc_pwm_decoder_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_COUNTER_VALUE);
  localparam logic [CNT_W-1:0] CNT_HIGH = CNT_W'(HIGH_COUNTER_VALUE);
  localparam logic [CNT_W-1:0] CNT_LOW  = CNT_W'(LOW_COUNTER_VALUE);
  localparam logic [1:0]       PRIME_FULL = 2'(PRIME_CYCLES);

  if (TIMEOUT_VALUE < 1) begin : g_bad_timeout
    $error("pwm_channel: TIMEOUT_VALUE must be at least 1");
  end

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  sync_out;
  logic                  level_q;
  logic                  rise_q;
  logic                  fall_q;
  logic [1:0]            prime_q;
  logic                  primed;

  pwm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic             valid_q, valid_d;
  logic             error_q, error_d;
  logic             switch_q, switch_d;
  logic             lost;

  assign sync_out = sync_q[SYNC_DEPTH-1];
  assign primed   = (prime_q == PRIME_FULL);

  // Synchronize the pin, keep a delayed copy, and register rise/fall events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      prime_q <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_DEPTH-2:0], bus.pwm[IDX]};
      level_q <= sync_out;
      rise_q  <= sync_out & ~level_q;
      fall_q  <= ~sync_out & level_q;
      if (!primed) prime_q <= prime_q + 2'd1;
    end
  end

  // FSM, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      width_q  <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      switch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      width_q  <= width_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
      switch_q <= switch_d;
    end
  end

  // Next state: leave IDLE only once the pipeline holds a real low sample,
  // so a pulse already in flight (e.g. across reset) is never measured.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    width_d  = width_q;
    switch_d = switch_q;
    valid_d  = 1'b0;
    error_d  = 1'b0;
    if (!bus.enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (primed && !sync_out && !level_q) state_d = WAIT_RISE;
        end
        WAIT_RISE: begin
          if (rise_q) begin
            state_d = MEASURE;
            cnt_d   = CNT_W'(1);
          end
        end
        MEASURE: begin
          if (fall_q) begin
            width_d = cnt_q;
            valid_d = 1'b1;
            if (cnt_q > CNT_HIGH)     switch_d = 1'b1;
            else if (cnt_q < CNT_LOW) switch_d = 1'b0;
            state_d = WAIT_RISE;
          end else if (level_q) begin
            if (cnt_q >= CNT_MAX - CNT_W'(1)) begin
              cnt_d   = CNT_MAX;
              error_d = 1'b1;
              state_d = OVERRUN;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        OVERRUN: begin
          if (fall_q) begin
            state_d = WAIT_RISE;
            cnt_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (lost && !valid_d) switch_d = 1'b0;
  end

`ifdef FAILSAFE_EN
  localparam int               TMR_W   = $clog2(TIMEOUT_VALUE + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_VALUE);

  logic [TMR_W-1:0] timer_q;

  assign lost = (timer_q == TMR_MAX);

  // Cycles since the last valid strobe, counted while enabled, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else if (valid_d) begin
      timer_q <= '0;
    end else if (bus.enable && !lost) begin
      timer_q <= timer_q + TMR_W'(1);
    end
  end
`else
  assign lost = 1'b0;
`endif

  assign bus.width[IDX*CNT_W +: CNT_W] = width_q;
  assign bus.valid[IDX]                = valid_q;
  assign bus.sw[IDX]                   = switch_q & ~lost;
  assign bus.error[IDX]                = error_q;
  assign bus.signal_lost[IDX]          = lost;
  assign bus.state[2*IDX +: 2]         = state_q;

endmodule

// File: rtl/rc_pwm_decoder.sv
// RC PWM decoder top: NUM_CH independent pulse-width channels.
// Build option: FAILSAFE_EN enables per-channel signal-loss detection.
module rc_pwm_decoder
  import pwm_pkg::*;
#(
  parameter int NUM_CH             = 4,
  parameter int CNT_W              = 12,
  parameter int MAX_COUNTER_VALUE  = 2000,
  parameter int HIGH_COUNTER_VALUE = 1800,
  parameter int LOW_COUNTER_VALUE  = 1200,
  parameter int TIMEOUT_VALUE      = 25000
) (
  input  logic                    clock_i,
  input  logic                    reset_n_i,
  input  logic                    enable_i,
  input  logic [NUM_CH-1:0]       pwm_i,
  output logic [NUM_CH*CNT_W-1:0] width_o,
  output logic [NUM_CH-1:0]       valid_o,
  output logic [NUM_CH-1:0]       switch_o,
  output logic [NUM_CH-1:0]       error_o,
  output logic [NUM_CH-1:0]       signal_lost_o
);

  if (!params_legal(LOW_COUNTER_VALUE, HIGH_COUNTER_VALUE, MAX_COUNTER_VALUE, CNT_W)) begin : g_bad_params
    $error("rc_pwm_decoder: need LOW < HIGH < MAX < 2**CNT_W");
  end

  rc_pwm_decoder_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  assign bus.enable = enable_i;
  assign bus.pwm    = pwm_i;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    pwm_channel #(
      .IDX               (k),
      .CNT_W             (CNT_W),
      .MAX_COUNTER_VALUE (MAX_COUNTER_VALUE),
      .HIGH_COUNTER_VALUE(HIGH_COUNTER_VALUE),
      .LOW_COUNTER_VALUE (LOW_COUNTER_VALUE),
      .TIMEOUT_VALUE     (TIMEOUT_VALUE)
    ) u_ch (
      .clk  (clock_i),
      .rst_n(reset_n_i),
      .bus  (bus)
    );
  end

  assign width_o       = bus.width;
  assign valid_o       = bus.valid;
  assign switch_o      = bus.sw;
  assign error_o       = bus.error;
  assign signal_lost_o = bus.signal_lost;

endmodule

// File: tb/tb_rc_pwm_decoder.sv
// Testbench for rc_pwm_decoder: directed scenarios plus randomized pulse trains,
// checked against a pulse-level reference model (high-run lengths -> events).
module tb_rc_pwm_decoder;

  localparam int NUM_CH   = 4;
  localparam int CNT_W    = 12;
  localparam int MAX_CNT  = 2000;
  localparam int HIGH_CNT = 1800;
  localparam int LOW_CNT  = 1200;
  localparam int TIMEOUT  = 25000;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rc_pwm_decoder_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) tb_bus ();

  rc_pwm_decoder #(
    .NUM_CH            (NUM_CH),
    .CNT_W             (CNT_W),
    .MAX_COUNTER_VALUE (MAX_CNT),
    .HIGH_COUNTER_VALUE(HIGH_CNT),
    .LOW_COUNTER_VALUE (LOW_CNT),
    .TIMEOUT_VALUE     (TIMEOUT)
  ) dut (
    .clock_i      (clk),
    .reset_n_i    (rst_n),
    .enable_i     (tb_bus.enable),
    .pwm_i        (tb_bus.pwm),
    .width_o      (tb_bus.width),
    .valid_o      (tb_bus.valid),
    .switch_o     (tb_bus.sw),
    .error_o      (tb_bus.error),
    .signal_lost_o(tb_bus.signal_lost)
  );

  assign tb_bus.state = dut.bus.state;

  // ---------------- scoreboard / reference model ----------------
  typedef enum logic {EV_VALID = 1'b0, EV_ERROR = 1'b1} ev_kind_e;
  typedef struct packed {
    logic [31:0]      due;
    logic [CNT_W-1:0] width;
    ev_kind_e         kind;
  } exp_ev_t;

  exp_ev_t exp_q[NUM_CH][$];
  int      run_len[NUM_CH];
  bit      armed[NUM_CH];
  int      m_width[NUM_CH];
  bit      m_sw[NUM_CH];
  int      m_timer[NUM_CH];
  bit      m_lost_prev[NUM_CH];
  int      cyc;
  int      checks;
  int      failures;
  int      pw[NUM_CH];
  int      po[NUM_CH];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      exp_q[k].delete();
      run_len[k]     = 0;
      armed[k]       = 1'b0;
      m_width[k]     = 0;
      m_sw[k]        = 1'b0;
      m_timer[k]     = 0;
      m_lost_prev[k] = 1'b0;
    end
  endtask

  // A high run of N samples that was preceded by a low sample yields a width
  // event 3 cycles after the closing low sample, or an error event 3 cycles
  // after the sample that brings the run to MAX_CNT.
  task automatic model_sample(input logic en, input logic [NUM_CH-1:0] pwm);
    exp_ev_t ev;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!en) begin
        armed[k]   = 1'b0;
        run_len[k] = 0;
      end else if (pwm[k]) begin
        if (armed[k]) begin
          run_len[k]++;
          if (run_len[k] == MAX_CNT) begin
            ev.due   = 32'(cyc + 3);
            ev.width = '0;
            ev.kind  = EV_ERROR;
            exp_q[k].push_back(ev);
          end
        end
      end else begin
        if (armed[k] && run_len[k] > 0 && run_len[k] < MAX_CNT) begin
          ev.due   = 32'(cyc + 3);
          ev.width = CNT_W'(run_len[k]);
          ev.kind  = EV_VALID;
          exp_q[k].push_back(ev);
        end
        run_len[k] = 0;
        armed[k]   = 1'b1;
      end
    end
  endtask

  task automatic check_cycle(input logic en, input logic rst_s);
    exp_ev_t ev;
    bit      exp_v;
    bit      exp_e;
    bit      lost;
    for (int k = 0; k < NUM_CH; k++) begin
      exp_v = 1'b0;
      exp_e = 1'b0;
      if (rst_s && exp_q[k].size() > 0 && exp_q[k][0].due == 32'(cyc)) begin
        ev = exp_q[k].pop_front();
        if (ev.kind == EV_VALID) begin
          exp_v      = 1'b1;
          m_width[k] = int'(ev.width);
          if (m_width[k] > HIGH_CNT)     m_sw[k] = 1'b1;
          else if (m_width[k] < LOW_CNT) m_sw[k] = 1'b0;
        end else begin
          exp_e = 1'b1;
        end
      end
`ifdef FAILSAFE_EN
      if (!rst_s)                           m_timer[k] = 0;
      else if (exp_v)                       m_timer[k] = 0;
      else if (en && m_timer[k] < TIMEOUT)  m_timer[k]++;
      lost = (m_timer[k] == TIMEOUT);
      if (lost) m_sw[k] = 1'b0;
`else
      lost = 1'b0;
      if (en) m_timer[k] = 0;
`endif
      if (exp_v || tb_bus.valid[k])
        check_eq($sformatf("valid[%0d]", k), 32'(tb_bus.valid[k]), 32'(exp_v));
      if (exp_e || tb_bus.error[k])
        check_eq($sformatf("error[%0d]", k), 32'(tb_bus.error[k]), 32'(exp_e));
      if (exp_v || exp_e || (cyc % 64 == 0) || (lost != m_lost_prev[k])) begin
        check_eq($sformatf("width[%0d]", k), 32'(tb_bus.width[k*CNT_W +: CNT_W]), 32'(m_width[k]));
        check_eq($sformatf("switch[%0d]", k), 32'(tb_bus.sw[k]), 32'(m_sw[k] & ~lost));
        check_eq($sformatf("lost[%0d]", k), 32'(tb_bus.signal_lost[k]), 32'(lost));
      end
      m_lost_prev[k] = lost;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    logic              en_s;
    logic              rst_s;
    logic [NUM_CH-1:0] pwm_s;
    @(posedge clk);
    cyc++;
    en_s  = tb_bus.enable;
    rst_s = rst_n;
    pwm_s = tb_bus.pwm;
    if (rst_s) model_sample(en_s, pwm_s);
    @(negedge clk);
    check_cycle(en_s, rst_s);
  endtask

  // Drives the pulses described by pw/po (width, start offset) then gap low cycles.
  task automatic run_pulses(input int gap);
    int span;
    span = 0;
    for (int k = 0; k < NUM_CH; k++)
      if (po[k] + pw[k] > span) span = po[k] + pw[k];
    for (int c = 0; c < span + gap; c++) begin
      for (int k = 0; k < NUM_CH; k++)
        tb_bus.pwm[k] = (c >= po[k]) && (c < po[k] + pw[k]);
      tick();
    end
    tb_bus.pwm = '0;
  endtask

  task automatic pulses(input int w0, input int w1, input int w2, input int w3, input int gap);
    pw[0] = w0; pw[1] = w1; pw[2] = w2; pw[3] = w3;
    for (int k = 0; k < NUM_CH; k++) po[k] = 0;
    run_pulses(gap);
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < NUM_CH; k++)
      check_eq($sformatf("%s_width[%0d]", tag, k), 32'(tb_bus.width[k*CNT_W +: CNT_W]), 32'd0);
    check_eq({tag, "_valid"}, 32'(tb_bus.valid), 32'd0);
    check_eq({tag, "_switch"}, 32'(tb_bus.sw), 32'd0);
    check_eq({tag, "_error"}, 32'(tb_bus.error), 32'd0);
    check_eq({tag, "_lost"}, 32'(tb_bus.signal_lost), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    checks        = 0;
    failures      = 0;
    cyc           = 0;
    tb_bus.enable = 1'b0;
    tb_bus.pwm    = '0;
    model_reset();

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n         = 1'b1;
    tb_bus.enable = 1'b1;
    pulses(0, 0, 0, 0, 10);

    // Nominal 1500 us pulse, switch stays at its reset value.
    pulses(1500, 0, 0, 0, 20);

    // Hysteresis: high, hold, low.
    pulses(1900, 0, 0, 0, 20);
    pulses(1500, 0, 0, 0, 20);
    pulses(1100, 0, 0, 0, 20);

    // Overrun then recovery.
    pulses(1900, 0, 0, 0, 20);
    pulses(2500, 0, 0, 0, 20);
    pulses(1500, 0, 0, 0, 20);

    // Reset in the middle of a pulse: the remainder must not be measured.
    pulses(0, 1900, 0, 0, 20);
    tb_bus.pwm[0] = 1'b1;
    for (int c = 0; c < 800; c++) tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all_zero("midrst");
    repeat (3) tick();
    rst_n = 1'b1;
    for (int c = 0; c < 1200; c++) tick();
    tb_bus.pwm = '0;
    pulses(0, 0, 0, 0, 20);
    pulses(1500, 0, 0, 0, 20);

    // Simultaneous edges on all channels.
    pulses(1000, 1300, 1700, 1950, 20);

    // Boundary widths around thresholds and saturation.
    pulses(1, MAX_CNT - 1, MAX_CNT, LOW_CNT, 30);
    pulses(HIGH_CNT, HIGH_CNT + 1, LOW_CNT - 1, 2, 30);

    // Disabled: pulses are ignored, outputs hold.
    tb_bus.enable = 1'b0;
    pulses(1500, 1900, 0, 1100, 20);
    tb_bus.enable = 1'b1;
    pulses(0, 0, 0, 0, 20);
    pulses(1300, 0, 1850, 0, 20);

    // Randomized pulse trains with per-channel offsets.
    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        case ($urandom_range(0, 9))
          0:       pw[k] = 0;
          1:       pw[k] = $urandom_range(1, 5);
          2:       pw[k] = $urandom_range(MAX_CNT - 2, MAX_CNT + 1);
          3:       pw[k] = $urandom_range(LOW_CNT - 2, LOW_CNT + 1);
          4:       pw[k] = $urandom_range(HIGH_CNT - 1, HIGH_CNT + 2);
          default: pw[k] = $urandom_range(1, MAX_CNT + 300);
        endcase
        po[k] = $urandom_range(0, 40);
      end
      run_pulses($urandom_range(8, 40));
    end

`ifdef FAILSAFE_EN
    // Signal loss after a long quiet period, recovery on the next pulse.
    pulses(1900, 0, 0, 0, 20);
    for (int c = 0; c < TIMEOUT + 10; c++) tick();
    pulses(1900, 0, 0, 0, 20);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rc_pwm_decoder.md
RC_PWM_DECODER -- requirements
Module: rc_pwm_decoder

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent RC PWM input channels.
REQ-002 SHALL have parameter CNT_W, default 12: width of the per-channel pulse counter and reported width.
REQ-003 SHALL have parameter MAX_COUNTER_VALUE, default 2000: counter saturation value, in clock cycles.
REQ-004 SHALL have parameter HIGH_COUNTER_VALUE, default 1800: a width above this sets the switch output HIGH.
REQ-005 SHALL have parameter LOW_COUNTER_VALUE, default 1200: a width below this sets the switch output LOW.
REQ-006 SHALL have parameter TIMEOUT_VALUE, default 25000: cycles without a valid pulse before signal loss is declared.
REQ-007 SHALL have port clock_i, input, 1 bit: single clock (1 MHz, so 1 cycle = 1 us).
REQ-008 SHALL have port reset_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port enable_i, input, 1 bit: global decode enable.
REQ-010 SHALL have port pwm_i, input, NUM_CH bits: asynchronous receiver pulse inputs.
REQ-011 SHALL have port width_o, output, NUM_CH*CNT_W bits: last valid width per channel; channel k at bits [k*CNT_W +: CNT_W].
REQ-012 SHALL have port valid_o, output, NUM_CH bits: one-cycle strobe when width_o[k] is updated.
REQ-013 SHALL have port switch_o, output, NUM_CH bits: hysteresis switch state per channel.
REQ-014 SHALL have port error_o, output, NUM_CH bits: one-cycle strobe on a pulse overrun.
REQ-015 SHALL have port signal_lost_o, output, NUM_CH bits: failsafe flag per channel.

Function
REQ-016 SHALL pass each pwm_i bit through a 2-flop synchronizer, followed by an edge-detect register.
REQ-017 SHALL give each channel an FSM with states IDLE, WAIT_RISE, MEASURE and OVERRUN.
REQ-018 SHALL move IDLE->WAIT_RISE only on a sampled low, so no pulse already in progress when leaving IDLE is ever measured.
REQ-019 SHALL move WAIT_RISE->MEASURE on a rising edge, with the counter loaded to 1.
REQ-020 SHALL, in MEASURE, increment the counter every cycle the synced input is high.
REQ-021 SHALL, on a falling edge in MEASURE, register the counter into width_o[k], pulse valid_o[k] for exactly 1 cycle, and return to WAIT_RISE.
REQ-022 SHALL report a high pulse of N clock cycles (1 <= N < MAX_COUNTER_VALUE) as width_o = N.
REQ-023 SHALL assert valid_o exactly 3 cycles after the first clock edge that samples pwm_i low.
REQ-024 SHALL, when the counter reaches MAX_COUNTER_VALUE while the input is still high, enter OVERRUN, pulse error_o[k] for 1 cycle, and leave width_o, valid_o and switch_o unchanged.
REQ-025 SHALL move OVERRUN->WAIT_RISE on a falling edge.
REQ-026 SHALL register switch_o[k] in the same cycle as valid_o[k]: 1 if width > HIGH_COUNTER_VALUE, 0 if width < LOW_COUNTER_VALUE, otherwise hold.
REQ-027 SHALL, while enable_i is 0, force all FSMs to IDLE, clear the counters, hold width_o and switch_o, and hold valid_o and error_o at 0.
REQ-028 SHALL keep channels fully independent, so simultaneous edges on several channels each produce their own valid_o in the same cycle.
REQ-029 SHALL use unsigned arithmetic for the counters, which saturate and never wrap.

Reset
REQ-030 SHALL, while reset_n_i is low, set asynchronously: synchronizers 0, FSM IDLE, counters 0, width_o 0, valid_o 0, switch_o 0, error_o 0, signal_lost_o 0.
REQ-031 SHALL, on reset assertion mid-pulse, discard the pulse, and after release not measure that pulse (per REQ-018).

Configuration
REQ-032 SHALL, with FAILSAFE_EN defined, count cycles per channel since the last valid_o[k] (while enabled), saturating at TIMEOUT_VALUE.
REQ-033 SHALL, with FAILSAFE_EN defined and the count at TIMEOUT_VALUE, set signal_lost_o[k] to 1 and force switch_o[k] to 0; both clear on the next valid_o[k].
REQ-034 SHALL, without FAILSAFE_EN, tie signal_lost_o to 0, keep the port present, and synthesize no timeout counter.

Structure
REQ-035 SHALL place the FSM state enum, the synchronizer depth constant (2) and the parameter legality checks (LOW < HIGH < MAX < 2**CNT_W) in shared package pwm_pkg.
REQ-036 SHALL implement one channel (sync, FSM, counter, hysteresis, failsafe) in sub-module pwm_channel, instantiated NUM_CH times by generate.

Verification
REQ-037 SHALL cover: pwm_i[0] high 1500 cycles -> width_o[0]=1500, valid_o[0] a single pulse 3 cycles after the fall, switch_o[0] unchanged (0).
REQ-038 SHALL cover: pulses of 1900, then 1500, then 1100 -> switch_o 1, 1 (held), then 0.
REQ-039 SHALL cover: pulse of 2500 -> error_o a single pulse at count 2000, no valid_o, width_o keeps its old value; the next 1500 pulse is measured correctly.
REQ-040 SHALL cover: reset_n_i pulled low at count 800 with pwm_i still high -> all outputs 0 immediately, no valid_o for the remainder of that pulse, and the next full pulse is measured.
REQ-041 SHALL cover: channels 0..3 given simultaneous 1000/1300/1700/1950 pulses -> all four valid_o in the same cycle with the correct widths.
REQ-042 SHALL cover (FAILSAFE_EN): switch_o=1, then 25000 idle cycles -> signal_lost_o=1 and switch_o=0; the next 1900 pulse -> signal_lost_o=0 and switch_o=1.
